// File: rtl/wb_commit_if.sv
// Writeback/commit port bundle: MEM/WB slot, late-result handshake and register-file write port.
// Carries retire_count when WB_RETIRE_CNT_EN is defined.
interface wb_commit_if #(
    parameter int LATE_DEPTH = 2
);
    localparam int CNT_W = $clog2(LATE_DEPTH + 1);

    logic             in_valid;
    logic             in_reg_write;
    logic [4:0]       in_rd;
    logic [1:0]       in_wb_sel;
    logic [31:0]      in_alu_result;
    logic [31:0]      in_pc4;
    logic [31:0]      in_mem_rdata;
    logic [2:0]       in_funct3;
    logic [1:0]       in_addr_lo;
    logic             late_valid;
    logic [4:0]       late_rd;
    logic [31:0]      late_data;
    logic             late_ready;
    logic             reg_write;
    logic [4:0]       wt_addr;
    logic [31:0]      wt_data;
    logic [CNT_W-1:0] late_count;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]      retire_count;
`endif

    modport master (
        output in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result, in_pc4,
               in_mem_rdata, in_funct3, in_addr_lo, late_valid, late_rd, late_data,
        input  late_ready, reg_write, wt_addr, wt_data, late_count
`ifdef WB_RETIRE_CNT_EN
        , input retire_count
`endif
    );

    modport slave (
        input  in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result, in_pc4,
               in_mem_rdata, in_funct3, in_addr_lo, late_valid, late_rd, late_data,
        output late_ready, reg_write, wt_addr, wt_data, late_count
`ifdef WB_RETIRE_CNT_EN
        , output retire_count
`endif
    );
endinterface

// File: rtl/wb_commit.sv
// Writeback/commit stage: load extraction plus arbitration of the single RF write port between
// the in-order slot and a small late-result FIFO. Optional retire counter under WB_RETIRE_CNT_EN.
module wb_commit #(
    parameter int LATE_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    wb_commit_if.slave bus
);
    localparam int CNT_W = $clog2(LATE_DEPTH + 1);
    localparam int PTR_W = (LATE_DEPTH > 1) ? $clog2(LATE_DEPTH) : 1;

    logic [4:0]       q_rd   [LATE_DEPTH];
    logic [31:0]      q_data [LATE_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pipe_wr, push, pop;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      load_v, sel_v;

    function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LATE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pipe_wr = bus.in_valid & bus.in_reg_write & (bus.in_rd != 5'd0);
    assign bus.late_ready = (count < CNT_W'(LATE_DEPTH));
    assign bus.late_count = count;
    // rd=0 late results are consumed by the handshake but never stored.
    assign push = bus.late_valid & bus.late_ready & (bus.late_rd != 5'd0);
    assign pop  = ~pipe_wr & (count != '0);

    always_comb begin
        byte_v = bus.in_mem_rdata[{bus.in_addr_lo, 3'b000} +: 8];
        half_v = bus.in_addr_lo[1] ? bus.in_mem_rdata[31:16] : bus.in_mem_rdata[15:0];
        case (bus.in_funct3)
            3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_v = {{16{half_v[15]}}, half_v};
            3'b100:  load_v = {24'd0, byte_v};
            3'b101:  load_v = {16'd0, half_v};
            default: load_v = bus.in_mem_rdata;
        endcase
        case (bus.in_wb_sel)
            2'd1:    sel_v = load_v;
            2'd2:    sel_v = bus.in_pc4;
            default: sel_v = bus.in_alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= bus.late_rd;
            q_data[wr_ptr] <= bus.late_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.reg_write <= 1'b0;
            bus.wt_addr   <= 5'd0;
            bus.wt_data   <= 32'd0;
        end else begin
            if (push) wr_ptr <= ptr_nxt(wr_ptr);
            if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Address/data hold on idle cycles; only the enable drops.
            if (pipe_wr) begin
                bus.reg_write <= 1'b1;
                bus.wt_addr   <= bus.in_rd;
                bus.wt_data   <= sel_v;
            end else if (pop) begin
                bus.reg_write <= 1'b1;
                bus.wt_addr   <= q_rd[rd_ptr];
                bus.wt_data   <= q_data[rd_ptr];
            end else begin
                bus.reg_write <= 1'b0;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)               bus.retire_count <= 32'd0;
        else if (bus.in_valid) bus.retire_count <= bus.retire_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit: reset, load extraction, late FIFO path,
// contention/backpressure, rd=0 handling and mid-operation reset.
module tb_wb_commit;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_commit_if #(.LATE_DEPTH(2)) bus ();
    wb_commit #(.LATE_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel);
        bus.in_valid     = v;
        bus.in_reg_write = rw;
        bus.in_rd        = rd;
        bus.in_wb_sel    = sel;
    endtask

    task automatic offer(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.late_valid = v;
        bus.late_rd    = rd;
        bus.late_data  = d;
    endtask

    task automatic wr_chk(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 32'(bus.reg_write), 32'(we));
        if (we) begin
            chk({tag, "_addr"}, 32'(bus.wt_addr), 32'(a));
            chk({tag, "_data"}, bus.wt_data, d);
        end
    endtask

    typedef struct { logic [1:0] sel; logic [2:0] f3; logic [1:0] lo; logic [31:0] exp; } ld_vec_t;
    ld_vec_t ld_vec [7];

    initial begin
        ld_vec[0] = '{2'd1, 3'b000, 2'd1, 32'hFFFF_FFF2};
        ld_vec[1] = '{2'd1, 3'b100, 2'd3, 32'h0000_0080};
        ld_vec[2] = '{2'd1, 3'b101, 2'd2, 32'h0000_8081};
        ld_vec[3] = '{2'd1, 3'b001, 2'd0, 32'hFFFF_F27F};
        ld_vec[4] = '{2'd1, 3'b010, 2'd2, 32'h8081_F27F};
        ld_vec[5] = '{2'd2, 3'b000, 2'd0, 32'h0000_1004};
        ld_vec[6] = '{2'd3, 3'b000, 2'd0, 32'hCAFE_0001};

        rst = 1'b1;
        slot(1'b0, 1'b0, 5'd0, 2'd0);
        bus.in_alu_result = 32'hCAFE_0001;
        bus.in_pc4        = 32'h0000_1004;
        bus.in_mem_rdata  = 32'h8081_F27F;
        bus.in_funct3     = 3'b000;
        bus.in_addr_lo    = 2'd0;
        offer(1'b1, 5'd3, 32'hDEAD_BEEF);

        // Reset held two cycles with a late offer pending.
        tick();
        tick();
        chk("rst_we", 32'(bus.reg_write), 32'd0);
        chk("rst_addr", 32'(bus.wt_addr), 32'd0);
        chk("rst_data", bus.wt_data, 32'd0);
        chk("rst_cnt", 32'(bus.late_count), 32'd0);
        chk("rst_rdy", 32'(bus.late_ready), 32'd1);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_retire", bus.retire_count, 32'd0);
`endif
        rst = 1'b0;
        offer(1'b0, 5'd0, 32'd0);
        tick();
        chk("rst_noacc_cnt", 32'(bus.late_count), 32'd0);
        chk("rst_noacc_we", 32'(bus.reg_write), 32'd0);

        // Load extraction and writeback selection.
        for (int i = 0; i < 7; i++) begin
            slot(1'b1, 1'b1, 5'd1 + 5'(i), ld_vec[i].sel);
            bus.in_funct3  = ld_vec[i].f3;
            bus.in_addr_lo = ld_vec[i].lo;
            tick();
            wr_chk($sformatf("ld%0d", i), 1'b1, 5'd1 + 5'(i), ld_vec[i].exp);
        end

        // Late result with idle pipeline: one extra cycle of latency.
        slot(1'b0, 1'b0, 5'd0, 2'd0);
        offer(1'b1, 5'd5, 32'h0000_1234);
        tick();
        offer(1'b0, 5'd0, 32'd0);
        chk("late_acc_cnt", 32'(bus.late_count), 32'd1);
        chk("late_acc_we", 32'(bus.reg_write), 32'd0);
        tick();
        wr_chk("late_wr", 1'b1, 5'd5, 32'h0000_1234);
        chk("late_wr_cnt", 32'(bus.late_count), 32'd0);
        tick();
        chk("late_idle_we", 32'(bus.reg_write), 32'd0);
        chk("late_idle_hold", 32'(bus.wt_addr), 32'd5);

        // Contention: pipeline owns the port, FIFO fills, third offer is held.
        slot(1'b1, 1'b1, 5'd10, 2'd0);
        bus.in_alu_result = 32'h0000_00A0;
        offer(1'b1, 5'd6, 32'h0000_0066);
        tick();
        wr_chk("ct_p0", 1'b1, 5'd10, 32'h0000_00A0);
        chk("ct_cnt1", 32'(bus.late_count), 32'd1);
        offer(1'b1, 5'd7, 32'h0000_0077);
        tick();
        chk("ct_cnt2", 32'(bus.late_count), 32'd2);
        chk("ct_rdy0", 32'(bus.late_ready), 32'd0);
        offer(1'b1, 5'd8, 32'h0000_0088);
        tick();
        tick();
        chk("ct_held_cnt", 32'(bus.late_count), 32'd2);
        wr_chk("ct_p1", 1'b1, 5'd10, 32'h0000_00A0);
        slot(1'b0, 1'b0, 5'd0, 2'd0);
        tick();
        wr_chk("ct_pop6", 1'b1, 5'd6, 32'h0000_0066);
        chk("ct_cnt_a", 32'(bus.late_count), 32'd1);
        tick();
        wr_chk("ct_pop7", 1'b1, 5'd7, 32'h0000_0077);
        chk("ct_cnt_b", 32'(bus.late_count), 32'd1);
        offer(1'b0, 5'd0, 32'd0);
        tick();
        wr_chk("ct_pop8", 1'b1, 5'd8, 32'h0000_0088);
        chk("ct_cnt_c", 32'(bus.late_count), 32'd0);

        // Zero register: rd=0 slot frees the port; late rd=0 is dropped.
        slot(1'b1, 1'b1, 5'd11, 2'd0);
        offer(1'b1, 5'd9, 32'h0000_0099);
        tick();
        wr_chk("z_p", 1'b1, 5'd11, 32'h0000_00A0);
        offer(1'b0, 5'd0, 32'd0);
        slot(1'b1, 1'b1, 5'd0, 2'd0);
        tick();
        wr_chk("z_pop9", 1'b1, 5'd9, 32'h0000_0099);
        chk("z_cnt", 32'(bus.late_count), 32'd0);
        slot(1'b0, 1'b0, 5'd0, 2'd0);
        offer(1'b1, 5'd0, 32'h0000_0055);
        tick();
        offer(1'b0, 5'd0, 32'd0);
        chk("z_late0_cnt", 32'(bus.late_count), 32'd0);
        chk("z_late0_we", 32'(bus.reg_write), 32'd0);
        tick();
        chk("z_late0_we2", 32'(bus.reg_write), 32'd0);

        // Mid-operation reset discards queued entries.
        slot(1'b1, 1'b1, 5'd12, 2'd0);
        offer(1'b1, 5'd13, 32'h0000_0013);
        tick();
        offer(1'b1, 5'd14, 32'h0000_0014);
        tick();
        chk("mr_cnt2", 32'(bus.late_count), 32'd2);
        offer(1'b0, 5'd0, 32'd0);
        slot(1'b0, 1'b0, 5'd0, 2'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_cnt0", 32'(bus.late_count), 32'd0);
        wr_chk("mr_rst", 1'b0, 5'd0, 32'd0);
        chk("mr_addr0", 32'(bus.wt_addr), 32'd0);
        slot(1'b1, 1'b0, 5'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mr_nowr%0d", i), 32'(bus.reg_write), 32'd0);
        end
        slot(1'b0, 1'b0, 5'd0, 2'd0);
        tick();
        chk("mr_nowr_end", 32'(bus.reg_write), 32'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", bus.retire_count, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
